microwave_cook_timer: RTL and testbench

- Cook-time controller for the microwave datapath.
- Accepts BCD keypad digits into an MM:SS register, counts down once per prescaled tick while cooking, and drives the magnetron enable and completion flag.
- Sits directly downstream of the input-settle counter: that counter's "settled" output qualifies start/resume requests, so cooking begins only after the front-panel inputs have settled.

---
 rtl/microwave_cook_timer.sv | 125 ++++++++++++
 tb/tb_microwave_cook_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_timer.sv
// microwave_cook_timer: BCD MM:SS cook-time controller with keypad entry,
// prescaled one-second countdown, magnetron gating and a latched done flag.
//   clock        system clock, rising edge
//   clear_n      asynchronous active-low reset
//   digit_valid  one-cycle keypad strobe; digit is the BCD key value
//   start/stop   one-cycle start/resume and stop/pause/cancel requests
//   door_closed  1 = door closed; settled = front-panel inputs stable
//   min_tens..sec_ones  BCD display digits
//   state        0 IDLE, 1 SET, 2 COOK, 3 PAUSE
//   magnetron_on heater enable; done = cook-complete flag
module microwave_cook_timer #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       settled,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       magnetron_on,
    output logic       done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [1:0] IDLE = 2'd0, SET = 2'd1, COOK = 2'd2, PAUSE = 2'd3;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   time_q, time_d, time_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          tick, time_zero, start_ok;

    assign tick      = presc_q == TICK_LAST;
    assign time_zero = time_q == 16'h0000;
    assign start_ok  = door_closed && settled &&
                       ((state_q == SET && !time_zero) ||
                        (state_q == IDLE && time_zero) ||
                        state_q == PAUSE);

    // Seconds are decremented digit-wise, so values above 59 count down literally
    always_comb begin
        time_dec = time_q;
        if (time_q[3:0] != 4'd0)
            time_dec[3:0] = time_q[3:0] - 4'd1;
        else if (time_q[7:4] != 4'd0)
            time_dec[7:0] = {time_q[7:4] - 4'd1, 4'd9};
        else begin
            time_dec[7:0]  = 8'h59;
            time_dec[15:8] = (time_q[11:8] != 4'd0) ? {time_q[15:12], time_q[11:8] - 4'd1}
                                                    : {time_q[15:12] - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Event priority: stop, then door open during COOK, then start, then digit.
    // The countdown runs in COOK whenever neither stop nor door-open intervened.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        done_d  = done_q;
        if (stop) begin
            done_d = 1'b0;
            if (state_q == COOK)
                state_d = PAUSE;
            else begin
                state_d = IDLE;
                time_d  = '0;
            end
        end else if (!door_closed && state_q == COOK)
            state_d = PAUSE;
        else begin
            if (start) begin
                done_d = 1'b0;
                if (start_ok) begin
                    state_d = COOK;
                    presc_d = '0;
                    if (state_q == IDLE)
                        time_d = 16'h0030;
                end
            end else if (digit_valid && digit <= 4'd9 && (state_q == IDLE || state_q == SET)) begin
                time_d  = {time_q[11:0], digit};
                state_d = SET;
                done_d  = 1'b0;
            end
            if (state_q == COOK) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    time_d = time_dec;
                    if (time_dec == 16'h0000) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        magnetron_on = state_q == COOK && door_closed;
        state        = state_q;
        done         = done_q;
        {min_tens, min_ones, sec_tens, sec_ones} = time_q;
    end
endmodule

// File: tb/tb_microwave_cook_timer.sv
// tb_microwave_cook_timer: scoreboard bench with directed and random stimulus against an arithmetic model.
module tb_microwave_cook_timer;
    localparam int TD = 4;
    logic       clock = 1'b0, clear_n = 1'b0;
    logic       digit_valid = 1'b0, start = 1'b0, stop = 1'b0, door_closed = 1'b1, settled = 1'b1;
    logic [3:0] digit = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       magnetron_on, done;
    int errors = 0, checks = 0;
    int m_st, m_min, m_sec, m_p;
    bit m_done;
    logic [18:0] exp_q[$];

    microwave_cook_timer #(.TICK_DIV(TD)) dut (
        .clock(clock), .clear_n(clear_n), .digit_valid(digit_valid), .digit(digit),
        .start(start), .stop(stop), .door_closed(door_closed), .settled(settled),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .state(state), .magnetron_on(magnetron_on), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] disp();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_min = 0; m_sec = 0; m_p = 0; m_done = 0;
    endtask

    task automatic model_step();
        int t;
        bit was_cook;
        t = m_min * 100 + m_sec;
        was_cook = m_st == 2;
        if (stop) begin
            m_done = 0;
            if (m_st == 2) m_st = 3;
            else begin m_st = 0; m_min = 0; m_sec = 0; end
        end else if (!door_closed && m_st == 2)
            m_st = 3;
        else begin
            if (start) begin
                m_done = 0;
                if (door_closed && settled) begin
                    if ((m_st == 1 && t != 0) || m_st == 3) begin m_st = 2; m_p = 0; end
                    else if (m_st == 0 && t == 0) begin m_st = 2; m_p = 0; m_min = 0; m_sec = 30; end
                end
            end else if (digit_valid && digit <= 9 && m_st <= 1) begin
                t = (t * 10 + int'(digit)) % 10000;
                m_min = t / 100; m_sec = t % 100; m_st = 1; m_done = 0;
            end
            if (was_cook) begin
                if (m_p == TD - 1) begin
                    m_p = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_sec = 59; m_min--; end
                    if (m_min == 0 && m_sec == 0) begin m_st = 0; m_done = 1; end
                end else m_p++;
            end
        end
    endtask

    task automatic drive(input bit dv, input int d, input bit st, input bit sp, input bit dc, input bit se);
        digit_valid = dv; digit = 4'(d); start = st; stop = sp; door_closed = dc; settled = se;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        exp_q.push_back({2'(m_st), disp(), m_done});
        #1;
    endtask

    task automatic cyc(input bit dv, input int d, input bit st, input bit sp, input bit dc, input bit se);
        drive(dv, d, st, sp, dc, se);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 1);
    endtask

    task automatic key(input int d);
        cyc(1, d, 0, 0, 1, 1);
    endtask

    task automatic clear_all();
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
    endtask

    always @(negedge clock) begin
        logic [18:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", {state, min_tens, min_ones, sec_tens, sec_ones, done}, e);
            chk("magnetron", magnetron_on, e[18:17] == 2'd2 && door_closed);
        end
    end

    initial begin
        model_reset();
        #12;
        chk("reset_state", {state, min_tens, min_ones, sec_tens, sec_ones, done, magnetron_on}, 21'd0);
        @(posedge clock); #1;
        clear_n = 1'b1;

        key(1); key(0); key(5);
        cyc(0, 0, 1, 0, 1, 1);
        chk("start_105", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd2, 16'h0105});
        idle(4);
        chk("tick_104", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0104);
        idle(20);
        chk("borrow_059", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
        for (int i = 0; i < 400 && m_st != 0; i++) idle(1);
        chk("finish_done", {state, done, magnetron_on}, {2'd0, 1'b1, 1'b0});

        key(2);
        cyc(0, 0, 1, 0, 1, 0);
        chk("unsettled_start", {state, magnetron_on}, {2'd1, 1'b0});
        cyc(0, 0, 1, 0, 1, 1);
        chk("settled_start", state, 2'd2);
        clear_all();

        key(4); key(0);
        cyc(0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("door_cut", magnetron_on, 1'b0);
        tick();
        chk("door_pause", state, 2'd3);
        idle(2);
        chk("pause_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0040);
        cyc(0, 0, 1, 0, 1, 1);
        idle(3);
        chk("resume_wait", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0040);
        idle(1);
        chk("resume_dec", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0039);
        cyc(0, 0, 1, 1, 1, 1);
        chk("start_stop", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd3, 16'h0039});
        cyc(0, 0, 0, 1, 1, 1);
        chk("pause_cancel", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd0, 16'h0000});
        cyc(0, 0, 1, 0, 1, 1);
        chk("quick_start", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd2, 16'h0030});
        clear_all();

        key(9); key(9); key(9); key(9); key(7);
        chk("shift_9997", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9997);
        key(12);
        chk("bad_digit", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd1, 16'h9997});
        cyc(0, 0, 1, 0, 1, 1);
        key(3);
        chk("cook_digit", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd2, 16'h9997});
        clear_all();
        key(1); key(0); key(0); key(0);
        cyc(0, 0, 1, 0, 1, 1);
        idle(4);
        chk("min_borrow", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0959);
        clear_all();
        key(1); key(9); key(0);
        cyc(0, 0, 1, 0, 1, 1);
        idle(4);
        chk("sec_literal", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0189);
        clear_all();

        key(1); key(2);
        cyc(0, 0, 1, 0, 1, 1);
        idle(2);
        chk("pre_reset", {state, min_tens, min_ones, sec_tens, sec_ones}, {2'd2, 16'h0012});
        #2;
        clear_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("async_reset", {state, min_tens, min_ones, sec_tens, sec_ones, done, magnetron_on}, 21'd0);
        @(posedge clock); #1;
        clear_n = 1'b1;

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 11), $urandom_range(0, 9) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0);

        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
